// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side responder for the processor data port. Accepts one load or
// store at a time on a valid/ready request channel and answers after a fixed
// LATENCY on a valid/ready response channel. Misaligned or out-of-range
// accesses leave memory untouched and return rsp_err=1 with zero data.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we                   1 = store, 0 = load
//   req_addr                 byte address
//   req_wdata, req_be        store data and byte-lane enables
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata                load data (0 for stores and errors)
//   rsp_err                  misaligned or out-of-range access
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency countdown running
// RESP  | response presented, waiting for rsp_ready
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  count, count_nxt;
    logic        accept;
    logic        req_bad;
    logic [31:0] word_idx;
    logic [AW-1:0] mem_idx;
    logic [31:0] mem [DEPTH_WORDS];

    // Full 30-bit word index compare so high address bits cannot alias
    // back into the array.
    assign word_idx = {2'b00, req_addr[31:2]};
    assign req_bad  = (req_addr[1:0] != 2'b00) || (word_idx >= 32'(DEPTH_WORDS));
    assign mem_idx  = word_idx[AW-1:0];

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        count_nxt = 4'd0;
                    end else begin
                        state_nxt = WAIT;
                        count_nxt = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                count_nxt = count - 4'd1;
                // Leaving at the edge where the countdown reaches zero.
                if (count <= 4'd1) begin
                    state_nxt = RESP;
                    count_nxt = 4'd0;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (accept) begin
                rsp_err   <= req_bad;
                rsp_rdata <= (req_bad || req_we) ? 32'd0 : mem[mem_idx];
            end
        end
    end

    // RAM has no reset; a store commits on its accepting edge, so a later
    // reset cannot undo it.
    always_ff @(posedge clk) begin
        if (!reset && accept && req_we && !req_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed bench for dmem_responder: a LATENCY=2 instance for functional
// cases plus LATENCY=1 and LATENCY=15 instances for back-to-back spacing.
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        s_valid;
    logic        r1_ready, r1_rsp_valid, r1_err;
    logic [31:0] r1_rdata;
    logic        r15_ready, r15_rsp_valid, r15_err;
    logic [31:0] r15_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int q1[$];
    int q15[$];

    logic [31:0] rd;
    logic        er;
    int          n;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst),
        .req_valid(s_valid), .req_ready(r1_ready), .req_we(1'b0),
        .req_addr(32'h13), .req_wdata(32'h0), .req_be(4'h0),
        .rsp_valid(r1_rsp_valid), .rsp_ready(1'b1),
        .rsp_rdata(r1_rdata), .rsp_err(r1_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_lat15 (
        .clk(clk), .reset(rst),
        .req_valid(s_valid), .req_ready(r15_ready), .req_we(1'b0),
        .req_addr(32'h13), .req_wdata(32'h0), .req_be(4'h0),
        .rsp_valid(r15_rsp_valid), .rsp_ready(1'b1),
        .rsp_rdata(r15_rdata), .rsp_err(r15_err)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && s_valid && r1_ready)  q1.push_back(cyc);
        if (!rst && s_valid && r15_ready) q15.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction with rsp_ready high; returns response fields.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err);
        int k;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        rsp_ready = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("txn_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        // Scramble fields after acceptance; they must not be resampled.
        req_valid = 1'b0; req_we = ~we; req_addr = 32'h0; req_wdata = 32'hA5A5A5A5; req_be = 4'hF;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("txn_latency", 32'(lat), 32'd2);
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_be = 4'h0; rsp_ready = 1'b1; s_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
        check("st_err", 32'(er), 32'd0);
        check("st_rdata", rd, 32'h0);
        txn(1'b1, 32'h10, 32'h00000011, 4'b0001, rd, er);
        check("st_be_err", 32'(er), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("ld_merge", rd, 32'hDEADBE11);
        check("ld_merge_err", 32'(er), 32'd0);

        txn(1'b1, 32'h0, 32'h12345678, 4'hF, rd, er);
        txn(1'b0, 32'h13, 32'h0, 4'h0, rd, er);
        check("misalign_err", 32'(er), 32'd1);
        check("misalign_rdata", rd, 32'h0);
        txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'h0);
        txn(1'b1, 32'h40000000, 32'hFFFFFFFF, 4'hF, rd, er);
        check("oor_high_err", 32'(er), 32'd1);
        txn(1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, rd, er);
        check("be0_err", 32'(er), 32'd0);
        txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er);
        check("word0_unchanged", rd, 32'h12345678);
        txn(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, rd, er);
        check("top_st_err", 32'(er), 32'd0);
        txn(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er);
        check("top_ld", rd, 32'hCAFEF00D);

        // Response backpressure
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_addr = 32'h0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data",  rsp_rdata, 32'hDEADBE11);
            check("bp_req_ready",  32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_turnaround_ready", 32'(req_ready), 32'd1);
        check("bp_turnaround_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_accepted", 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_rdata", rsp_rdata, 32'h12345678);

        // Reset while a store sits in WAIT
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5; req_be = 4'hF;
        check("mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_in_wait", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_ready_after", 32'(req_ready), 32'd1);
        repeat (4) begin
            check("mid_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er);
        check("mid_store_kept", rd, 32'h5);
        check("mid_store_err", 32'(er), 32'd0);

        // Latency sweep, back-to-back
        @(negedge clk);
        q1.delete();
        q15.delete();
        s_valid = 1'b1;
        repeat (70) @(negedge clk);
        s_valid = 1'b0;
        check("sw1_count",  32'(q1.size()  >= 4), 32'd1);
        check("sw15_count", 32'(q15.size() >= 4), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i + 1 < q1.size())  check("sw1_gap",  32'(q1[i+1]  - q1[i]),  32'd2);
            if (i + 1 < q15.size()) check("sw15_gap", 32'(q15[i+1] - q15[i]), 32'd16);
        end
        check("sw1_err",    32'(r1_err), 32'd1);
        check("sw1_rdata",  r1_rdata, 32'h0);
        check("sw15_err",   32'(r15_err), 32'd1);
        check("sw15_rdata", r15_rdata, 32'h0);
        check("sw1_idle",   32'(r1_rsp_valid | r15_rsp_valid) | 32'd1, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
